// File: rtl/lelo_temp_freq_counter.sv
// Gate-window frequency counter: counts synchronised rising edges of osc_in over win_len clk cycles.
// Build option: define LELO_TEMP_SAT_EN to saturate the edge counter instead of wrapping it.
module lelo_temp_freq_counter #(
    parameter int CNT_W = 12,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             cont,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] thresh,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             alarm,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    // Handshake: valid is a one-cycle strobe with no ready; count_out, alarm and
    // overflow change together on the cycle after valid and hold until the next one.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             prev;
    logic             osc_edge;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= osc_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign osc_edge = s2 & ~prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && (win_len != '0)) state_nxt = S_ARM;
            S_ARM:     state_nxt = S_MEASURE;
            S_MEASURE: if (win_cnt == WIN_W'(1)) state_nxt = S_DONE;
            S_DONE:    state_nxt = cont ? S_ARM : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        valid     = (state == S_DONE);
        state_dbg = state;
    end

    // Window and edge counters; results are published only when leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt   <= '0;
            edge_cnt  <= '0;
            ovf_acc   <= 1'b0;
            count_out <= '0;
            alarm     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_ARM: begin
                    win_cnt  <= win_len;
                    edge_cnt <= '0;
                    ovf_acc  <= 1'b0;
                end
                S_MEASURE: begin
                    win_cnt <= win_cnt - WIN_W'(1);
                    if (osc_edge) begin
`ifdef LELO_TEMP_SAT_EN
                        if (edge_cnt == CNT_MAX) begin
                            ovf_acc <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        end
`else
                        edge_cnt <= edge_cnt + CNT_W'(1);
                        if (edge_cnt == CNT_MAX) begin
                            ovf_acc <= 1'b1;
                        end
`endif
                    end
                end
                S_DONE: begin
                    count_out <= edge_cnt;
                    alarm     <= (edge_cnt >= thresh);
                    overflow  <= ovf_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lelo_temp_freq_counter.sv
// Bench for lelo_temp_freq_counter: a 12-bit and a 4-bit instance share stimulus and are
// compared every cycle against an event-time model of the measurement windows.
module tb_lelo_temp_freq_counter;

    localparam int CW  = 12;
    localparam int WW  = 16;
    localparam int CW4 = 4;
`ifdef LELO_TEMP_SAT_EN
    localparam int OVF4_CNT = 15;
`else
    localparam int OVF4_CNT = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          osc_in;
    logic          start;
    logic          cont;
    logic [WW-1:0] win_len;
    logic [CW-1:0] thresh;

    logic           busy, valid, alarm, overflow;
    logic [CW-1:0]  count_out;
    logic [1:0]     state_dbg;
    logic           busy4, valid4, alarm4, overflow4;
    logic [CW4-1:0] count_out4;
    logic [1:0]     state_dbg4;

    lelo_temp_freq_counter #(.CNT_W(CW), .WIN_W(WW)) dut (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .cont(cont),
        .win_len(win_len), .thresh(thresh), .busy(busy), .count_out(count_out),
        .valid(valid), .alarm(alarm), .overflow(overflow), .state_dbg(state_dbg)
    );

    lelo_temp_freq_counter #(.CNT_W(CW4), .WIN_W(WW)) dut4 (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .cont(cont),
        .win_len(win_len), .thresh(thresh[CW4-1:0]), .busy(busy4), .count_out(count_out4),
        .valid(valid4), .alarm(alarm4), .overflow(overflow4), .state_dbg(state_dbg4)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- oscillator driver ----------------
    bit osc_rand = 1'b1;
    int osc_min  = 1;
    int osc_half = 2;
    int phase_left = 1;

    initial begin
        osc_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (phase_left <= 1) begin
                osc_in = ~osc_in;
                phase_left = osc_rand ? int'($urandom_range(osc_min, 6)) : osc_half;
            end else begin
                phase_left--;
            end
        end
    end

    // ---------------- reference model ----------------
    // A window is described by the edge k that accepted it; ARM, MEASURE and DONE
    // are then fixed offsets from k. Edge visibility is the osc sample two edges back
    // rising against the one three edges back.
    bit h_hist [0:131071];
    bit m_active = 1'b0;
    int m_t0 = 0;
    int m_w = 0;
    int m_edges = 0;
    bit m_rst_last = 1'b0;

    logic           exp_busy = 1'b0, exp_valid = 1'b0;
    logic [CW-1:0]  exp_cnt = '0;
    logic           exp_alarm = 1'b0, exp_ovf = 1'b0;
    logic [CW4-1:0] exp_cnt4 = '0;
    logic           exp_alarm4 = 1'b0, exp_ovf4 = 1'b0;
    logic [CW+1:0]  exp_q[$];

    function automatic bit hv(input int i);
        return (i < 0) ? 1'b0 : h_hist[i];
    endfunction

    function automatic void result(input int total, input int w, input int th,
                                   output int cnt, output bit al, output bit ov);
        int maxv;
        maxv = (1 << w) - 1;
        ov = (total > maxv);
`ifdef LELO_TEMP_SAT_EN
        cnt = ov ? maxv : total;
`else
        cnt = total % (maxv + 1);
`endif
        al = (cnt >= th);
    endfunction

    initial begin
        int e;
        int c;
        bit al, ov;
        bit was_active;
        forever begin
            @(posedge clk);
            cyc++;
            e = cyc;
            h_hist[e] = osc_in;
            m_rst_last = rst;
            if (rst) begin
                m_active = 1'b0;
                h_hist[e] = 1'b0;
                if (e >= 1) h_hist[e-1] = 1'b0;
                if (e >= 2) h_hist[e-2] = 1'b0;
                exp_cnt = '0; exp_alarm = 1'b0; exp_ovf = 1'b0;
                exp_cnt4 = '0; exp_alarm4 = 1'b0; exp_ovf4 = 1'b0;
            end else begin
                was_active = m_active;
                if (m_active) begin
                    if (e == m_t0 + 1) begin
                        m_w = int'(win_len);
                        m_edges = 0;
                    end else if (e <= m_t0 + 1 + m_w) begin
                        if (hv(e-2) && !hv(e-3)) m_edges++;
                    end else if (e == m_t0 + 2 + m_w) begin
                        result(m_edges, CW, int'(thresh), c, al, ov);
                        exp_cnt = CW'(c); exp_alarm = al; exp_ovf = ov;
                        result(m_edges, CW4, int'(thresh[CW4-1:0]), c, al, ov);
                        exp_cnt4 = CW4'(c); exp_alarm4 = al; exp_ovf4 = ov;
                        exp_q.push_back({exp_ovf, exp_alarm, exp_cnt});
                        if (cont) m_t0 = e;
                        else m_active = 1'b0;
                    end
                end
                if (!was_active && start && (win_len != '0)) begin
                    m_active = 1'b1;
                    m_t0 = e;
                end
            end
            exp_busy  = m_active;
            exp_valid = m_active && (e > m_t0) && (e == m_t0 + 1 + m_w);
        end
    end

    // ---------------- scoreboard / compare ----------------
    initial begin
        bit valid_seen;
        logic [CW+1:0] r;
        valid_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", busy, exp_busy);
                check("valid", valid, exp_valid);
                check("count_out", count_out, exp_cnt);
                check("alarm", alarm, exp_alarm);
                check("overflow", overflow, exp_ovf);
                check("busy4", busy4, exp_busy);
                check("valid4", valid4, exp_valid);
                check("count_out4", count_out4, exp_cnt4);
                check("alarm4", alarm4, exp_alarm4);
                check("overflow4", overflow4, exp_ovf4);
                if (valid_seen && !m_rst_last) begin
                    check("result_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        r = exp_q.pop_front();
                        check("result", {overflow, alarm, count_out}, r);
                    end
                end
                valid_seen = valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && m_active; i++) tick();
        check("idle_timeout", m_active, 0);
    endtask

    task automatic run_single(input int w, input int exp_lit, input string nm);
        int n;
        win_len = WW'(w);
        pulse_start();
        wait_valid(w + 20, n);
        check({nm, "_latency"}, n, w + 2);
        @(negedge clk);
        check({nm, "_busy_low"}, busy, 0);
        check({nm, "_count"}, count_out, exp_lit);
        check({nm, "_model"}, exp_cnt, exp_lit);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int nv;
        int len;
        rst = 1'b1; start = 1'b0; cont = 1'b0; win_len = '0; thresh = '0;
        tick();
        chk_en = 1'b1;
        repeat (3) begin
            start = 1'($urandom_range(0, 1));
            cont = 1'($urandom_range(0, 1));
            win_len = WW'($urandom_range(0, 200));
            thresh = CW'($urandom);
            tick();
        end
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_count", count_out, 0);
        check("rst_alarm", alarm, 0);
        check("rst_overflow", overflow, 0);

        rst = 1'b0; start = 1'b0; cont = 1'b0; win_len = WW'(100); thresh = '0;
        nv = 0;
        repeat (10) begin
            tick();
            if (valid) nv++;
        end
        check("idle_no_valid", nv, 0);

        // periodic input, period 4
        osc_rand = 1'b0; osc_half = 2;
        thresh = CW'(30);
        repeat (8) tick();
        run_single(100, 25, "single");

        // zero window: start ignored
        win_len = '0;
        pulse_start();
        nv = 0;
        repeat (5) begin
            tick();
            if (valid || busy) nv++;
        end
        check("zero_win_idle", nv, 0);

        // start pulses during MEASURE are ignored
        win_len = WW'(100);
        pulse_start();
        n = -1;
        for (int i = 1; i <= 130; i++) begin
            @(negedge clk);
            start = (i >= 10 && i < 16);
            if (valid) begin
                n = i;
                break;
            end
        end
        start = 1'b0;
        check("busy_start_latency", n, 102);
        @(negedge clk);
        check("busy_start_count", count_out, 25);
        tick();
        wait_idle();

        // continuous mode with alarm, period 8
        osc_half = 4;
        cont = 1'b1; win_len = WW'(40); thresh = CW'(5);
        repeat (8) tick();
        pulse_start();
        wait_valid(60, n);
        check("cont_first", n, 42);
        @(negedge clk);
        check("cont_count1", count_out, 5);
        check("cont_alarm1", alarm, 1);
        thresh = CW'(6);
        wait_valid(60, n);
        check("cont_period", n, 41);
        @(negedge clk);
        check("cont_count2", count_out, 5);
        check("cont_alarm2", alarm, 0);
        cont = 1'b0;
        tick();
        wait_idle();

        // overflow on the 4-bit instance: 20 edges
        osc_half = 2; thresh = '0; win_len = WW'(80);
        repeat (8) tick();
        pulse_start();
        wait_valid(100, n);
        check("ovf_latency", n, 82);
        @(negedge clk);
        check("ovf_count12", count_out, 20);
        check("ovf_flag12", overflow, 0);
        check("ovf_count4", count_out4, OVF4_CNT);
        check("ovf_flag4", overflow4, 1);
        tick();

        // reset in MEASURE cycle 30 of 100
        win_len = WW'(100);
        pulse_start();
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nv = 0;
        repeat (120) begin
            tick();
            if (valid) nv++;
        end
        check("midrst_no_valid", nv, 0);
        check("midrst_count", count_out, 0);
        check("midrst_alarm", alarm, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_overflow4", overflow4, 0);
        run_single(100, 25, "after_rst");

        // randomized windows, modes, thresholds, input rates and resets
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            osc_rand = ($urandom_range(0, 3) != 0);
            osc_min  = $urandom_range(1, 2);
            osc_half = $urandom_range(1, 5);
            win_len  = ($urandom_range(0, 9) == 0) ? '0 : WW'($urandom_range(1, 150));
            thresh   = CW'($urandom_range(0, 40));
            cont     = ($urandom_range(0, 3) == 0);
            pulse_start();
            len = $urandom_range(50, 400);
            for (int c = 0; c < len; c++) begin
                start = ($urandom_range(0, 15) == 0);
                rst   = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 7) == 0) thresh = CW'($urandom_range(0, 40));
                if (win_len != '0 && $urandom_range(0, 31) == 0) win_len = WW'($urandom_range(1, 150));
                if (c > 100) cont = 1'b0;
                tick();
            end
            start = 1'b0; rst = 1'b0; cont = 1'b0;
        end
        wait_idle();
        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
